// File: rtl/hazard_scheduler.sv
// hazard_scheduler
// Decode-stage hazard controller. Tracks the three in-flight writers
// (EX, MEM, WB) in a small scoreboard, publishes them as a forwarding vector,
// inserts load-use bubbles, flushes wrong-path fetches on an EX redirect and
// sequences the pipeline drain after a HALT.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   Id_*          decode-stage instruction description (valid, sources, uses,
//                 destination, regwrite, load, halt)
//   Ex_redirect   branch/jump resolved taken in EX this cycle
//   Stall_if      hold PC and the IF/ID register
//   Stall_id      hold decode (do not advance into EX)
//   Bubble_ex     load a NOP into the ID/EX register
//   Flush_id      clear the IF/ID register
//   Fwd_vector    {WBv,WBreg,MEMv,MEMreg,EXv,EXreg}
//   Halted        pipeline drained after HALT, sticky until rst
//   err           sticky protocol error
module hazard_scheduler #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Id_valid,
    input  logic [2:0]  Id_src_a,
    input  logic [2:0]  Id_src_b,
    input  logic        Id_use_a,
    input  logic        Id_use_b,
    input  logic [2:0]  Id_dest,
    input  logic        Id_regwrite,
    input  logic        Id_memread,
    input  logic        Id_halt,
    input  logic        Ex_redirect,
    output logic        Stall_if,
    output logic        Stall_id,
    output logic        Bubble_ex,
    output logic        Flush_id,
    output logic [11:0] Fwd_vector,
    output logic        Halted,
    output logic        err
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    // Counters are loaded with "remaining cycles after this one".
    localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    logic [1:0] state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       err_set;

    logic       ex_valid, ex_load, mem_valid, wb_valid;
    logic [2:0] ex_dest, mem_dest, wb_dest;

    logic       load_use;
    logic       id_writes;

    assign id_writes = Id_valid & Id_regwrite;

    assign load_use = Id_valid & ex_valid & ex_load &
                      ((Id_use_a & (Id_src_a == ex_dest)) |
                       (Id_use_b & (Id_src_b == ex_dest)));

    // A load still in EX has no data yet, so it is not offered for forwarding.
    assign Fwd_vector = {wb_valid, wb_dest, mem_valid, mem_dest,
                         ex_valid & ~ex_load, ex_dest};

    assign Halted = (state == ST_HALTED);

    always_comb begin
        Stall_if  = 1'b0;
        Stall_id  = 1'b0;
        Bubble_ex = 1'b0;
        Flush_id  = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        err_set   = Id_valid & Id_halt & Id_regwrite;

        case (state)
            ST_RUN: begin
                // Redirect outranks everything: the ID instruction is wrong-path.
                if (Ex_redirect) begin
                    Flush_id  = 1'b1;
                    Bubble_ex = 1'b1;
                end else if (load_use) begin
                    Stall_if  = 1'b1;
                    Stall_id  = 1'b1;
                    Bubble_ex = 1'b1;
                    if (STALL_INIT != 4'd0) begin
                        state_nxt = ST_STALL;
                        cnt_nxt   = STALL_INIT;
                    end
                end else if (Id_valid & Id_halt) begin
                    Stall_if = 1'b1;
                    if (DRAIN_INIT != 4'd0) begin
                        state_nxt = ST_DRAIN;
                        cnt_nxt   = DRAIN_INIT;
                    end else begin
                        state_nxt = ST_HALTED;
                    end
                end
            end
            ST_STALL: begin
                if (Ex_redirect) begin
                    Flush_id  = 1'b1;
                    Bubble_ex = 1'b1;
                    state_nxt = ST_RUN;
                    cnt_nxt   = 4'd0;
                end else begin
                    Stall_if  = 1'b1;
                    Stall_id  = 1'b1;
                    Bubble_ex = 1'b1;
                    cnt_nxt   = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                // HALT is the youngest live instruction, so a redirect here is a protocol error.
                Stall_if = 1'b1;
                Flush_id = 1'b1;
                cnt_nxt  = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = ST_HALTED;
                end
                if (Ex_redirect) begin
                    err_set = 1'b1;
                end
            end
            default: begin
                Stall_if = 1'b1;
                Stall_id = 1'b1;
                if (Ex_redirect) begin
                    err_set = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= 4'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Scoreboard shift; frozen once halted. Invalid entries carry dest 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_dest   <= 3'd0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_dest  <= 3'd0;
            wb_valid  <= 1'b0;
            wb_dest   <= 3'd0;
        end else if (state != ST_HALTED) begin
            wb_valid  <= mem_valid;
            wb_dest   <= mem_dest;
            mem_valid <= ex_valid;
            mem_dest  <= ex_dest;
            if (Bubble_ex || !id_writes) begin
                ex_valid <= 1'b0;
                ex_dest  <= 3'd0;
                ex_load  <= 1'b0;
            end else begin
                ex_valid <= 1'b1;
                ex_dest  <= Id_dest;
                ex_load  <= Id_memread;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler
// Drives hazard_scheduler with directed scenarios followed by random traffic.
// A behavioural model predicts each cycle's outputs into a queue; a monitor on
// the falling edge pops and compares against the DUT.
module tb_hazard_scheduler;

    localparam int L_STALL = 3;
    localparam int L_DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        Id_valid, Id_use_a, Id_use_b, Id_regwrite, Id_memread, Id_halt;
    logic [2:0]  Id_src_a, Id_src_b, Id_dest;
    logic        Ex_redirect;
    logic        Stall_if, Stall_id, Bubble_ex, Flush_id, Halted, err;
    logic [11:0] Fwd_vector;

    always #5 clk = ~clk;

    hazard_scheduler #(
        .LOAD_STALL_CYCLES(L_STALL),
        .DRAIN_CYCLES(L_DRAIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Id_valid(Id_valid),
        .Id_src_a(Id_src_a),
        .Id_src_b(Id_src_b),
        .Id_use_a(Id_use_a),
        .Id_use_b(Id_use_b),
        .Id_dest(Id_dest),
        .Id_regwrite(Id_regwrite),
        .Id_memread(Id_memread),
        .Id_halt(Id_halt),
        .Ex_redirect(Ex_redirect),
        .Stall_if(Stall_if),
        .Stall_id(Stall_id),
        .Bubble_ex(Bubble_ex),
        .Flush_id(Flush_id),
        .Fwd_vector(Fwd_vector),
        .Halted(Halted),
        .err(err)
    );

    typedef struct packed {
        logic       valid;
        logic [2:0] src_a;
        logic [2:0] src_b;
        logic       use_a;
        logic       use_b;
        logic [2:0] dest;
        logic       regwrite;
        logic       memread;
        logic       halt;
        logic       redirect;
        logic       rst;
    } stim_t;

    typedef struct packed {
        logic        stall_if;
        logic        stall_id;
        logic        bubble;
        logic        flush;
        logic        halted;
        logic        err;
        logic [11:0] fwd;
        logic [11:0] mask;
    } exp_t;

    typedef struct packed {
        logic       v;
        logic [2:0] d;
        logic       ld;
    } ent_t;

    exp_t  exp_q[$];
    ent_t  ex_e, mem_e, wb_e;
    int    bubbles_left, drain_left;
    bit    m_halted, m_err, last_stall;
    int    checks = 0;
    int    failures = 0;

    function automatic stim_t mk(input logic valid, input int src_a, input int src_b,
                                 input logic use_a, input logic use_b, input int dest,
                                 input logic regwrite, input logic memread,
                                 input logic halt, input logic redirect);
        stim_t s;
        s.valid    = valid;
        s.src_a    = 3'(src_a);
        s.src_b    = 3'(src_b);
        s.use_a    = use_a;
        s.use_b    = use_b;
        s.dest     = 3'(dest);
        s.regwrite = regwrite;
        s.memread  = memread;
        s.halt     = halt;
        s.redirect = redirect;
        s.rst      = 1'b0;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic stim_t reset_stim();
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic logic [2:0] rand_reg();
        if ($urandom_range(0, 7) == 0) return 3'($urandom_range(0, 7));
        return 3'($urandom_range(0, 3));
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.valid    = ($urandom_range(0, 99) < 85);
        s.src_a    = rand_reg();
        s.src_b    = rand_reg();
        s.use_a    = ($urandom_range(0, 99) < 90);
        s.use_b    = ($urandom_range(0, 99) < 60);
        s.dest     = rand_reg();
        s.regwrite = ($urandom_range(0, 99) < 70);
        s.memread  = s.regwrite && ($urandom_range(0, 99) < 35);
        s.halt     = ($urandom_range(0, 99) < 2);
        if (s.halt) begin
            s.regwrite = ($urandom_range(0, 3) == 0);
            s.memread  = 1'b0;
        end
        s.redirect = ($urandom_range(0, 99) < 8);
        s.rst      = ($urandom_range(0, 199) == 0);
        return s;
    endfunction

    task automatic model_reset();
        ex_e         = '0;
        mem_e        = '0;
        wb_e         = '0;
        bubbles_left = 0;
        drain_left   = 0;
        m_halted     = 1'b0;
        m_err        = 1'b0;
        last_stall   = 1'b0;
    endtask

    // One cycle: drive inputs after the edge, predict the outputs for this
    // cycle, then advance the model to what the next edge should produce.
    task automatic apply_stimulus(input stim_t s);
        exp_t e;
        logic hazard;
        bit   was_halted, was_draining;
        @(posedge clk);
        #1;
        rst         = s.rst;
        Id_valid    = s.valid;
        Id_src_a    = s.src_a;
        Id_src_b    = s.src_b;
        Id_use_a    = s.use_a;
        Id_use_b    = s.use_b;
        Id_dest     = s.dest;
        Id_regwrite = s.regwrite;
        Id_memread  = s.memread;
        Id_halt     = s.halt;
        Ex_redirect = s.redirect;
        if (s.rst) begin
            model_reset();
            return;
        end

        e        = '0;
        e.fwd    = {wb_e.v, wb_e.d, mem_e.v, mem_e.d, ex_e.v & ~ex_e.ld, ex_e.d};
        e.mask   = {1'b1, {3{wb_e.v}}, 1'b1, {3{mem_e.v}}, 1'b1, {3{ex_e.v}}};
        e.halted = m_halted;
        e.err    = m_err;
        hazard   = s.valid && ex_e.v && ex_e.ld &&
                   ((s.use_a && s.src_a == ex_e.d) || (s.use_b && s.src_b == ex_e.d));
        was_halted   = m_halted;
        was_draining = (drain_left > 0);

        if (was_halted) begin
            e.stall_if = 1'b1;
            e.stall_id = 1'b1;
        end else if (was_draining) begin
            e.stall_if = 1'b1;
            e.flush    = 1'b1;
            drain_left--;
            if (drain_left == 0) m_halted = 1'b1;
        end else if (bubbles_left > 0 && s.redirect) begin
            e.flush      = 1'b1;
            e.bubble     = 1'b1;
            bubbles_left = 0;
        end else if (bubbles_left > 0) begin
            e.stall_if = 1'b1;
            e.stall_id = 1'b1;
            e.bubble   = 1'b1;
            bubbles_left--;
        end else if (s.redirect) begin
            e.flush  = 1'b1;
            e.bubble = 1'b1;
        end else if (hazard) begin
            e.stall_if   = 1'b1;
            e.stall_id   = 1'b1;
            e.bubble     = 1'b1;
            bubbles_left = L_STALL - 1;
        end else if (s.valid && s.halt) begin
            e.stall_if = 1'b1;
            drain_left = L_DRAIN - 1;
            if (drain_left == 0) m_halted = 1'b1;
        end

        if ((s.redirect && (was_halted || was_draining)) || (s.valid && s.halt && s.regwrite))
            m_err = 1'b1;

        if (!was_halted) begin
            wb_e  = mem_e;
            mem_e = ex_e;
            if (e.bubble || !(s.valid && s.regwrite)) ex_e = '0;
            else ex_e = '{v: 1'b1, d: s.dest, ld: s.memread};
        end

        exp_q.push_back(e);
        last_stall = e.stall_id;
    endtask

    task automatic check_output(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle with a prediction pending, compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("stall_if",   {11'd0, Stall_if},  {11'd0, e.stall_if});
            check_output("stall_id",   {11'd0, Stall_id},  {11'd0, e.stall_id});
            check_output("bubble_ex",  {11'd0, Bubble_ex}, {11'd0, e.bubble});
            check_output("flush_id",   {11'd0, Flush_id},  {11'd0, e.flush});
            check_output("halted",     {11'd0, Halted},    {11'd0, e.halted});
            check_output("err",        {11'd0, err},       {11'd0, e.err});
            check_output("fwd_vector", Fwd_vector & e.mask, e.fwd & e.mask);
        end
    end

    initial begin
        stim_t cur, prev;
        int    halted_cycles;

        rst = 1'b1;
        Id_valid = 0; Id_src_a = 0; Id_src_b = 0; Id_use_a = 0; Id_use_b = 0;
        Id_dest = 0; Id_regwrite = 0; Id_memread = 0; Id_halt = 0; Ex_redirect = 0;
        model_reset();

        apply_stimulus(reset_stim());
        apply_stimulus(reset_stim());
        apply_stimulus(idle());

        // ld r2 ; add r3,r2,r1 held in decode through the load-use stall
        apply_stimulus(mk(1, 0, 0, 1, 0, 2, 1, 1, 0, 0));
        for (int i = 0; i < L_STALL + 1; i++) apply_stimulus(mk(1, 2, 1, 1, 1, 3, 1, 0, 0, 0));
        repeat (3) apply_stimulus(idle());

        // add r1 ; sub r4,r1,r5 flows with forwarding only
        apply_stimulus(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        apply_stimulus(mk(1, 1, 5, 1, 1, 4, 1, 0, 0, 0));
        repeat (3) apply_stimulus(idle());

        // ld r2 ; addi r6 with src_b==2 unused: stall only through port A
        apply_stimulus(mk(1, 0, 0, 1, 0, 2, 1, 1, 0, 0));
        for (int i = 0; i < L_STALL + 1; i++) apply_stimulus(mk(1, 2, 2, 1, 0, 6, 1, 0, 0, 0));
        apply_stimulus(mk(1, 0, 0, 1, 0, 2, 1, 1, 0, 0));
        apply_stimulus(mk(1, 3, 2, 1, 0, 6, 1, 0, 0, 0));
        repeat (3) apply_stimulus(idle());

        // load-use hazard coinciding with a redirect
        apply_stimulus(mk(1, 0, 0, 1, 0, 2, 1, 1, 0, 0));
        apply_stimulus(mk(1, 2, 1, 1, 1, 3, 1, 0, 0, 1));
        repeat (2) apply_stimulus(idle());

        // reset in the middle of a multi-cycle stall
        apply_stimulus(mk(1, 0, 0, 1, 0, 2, 1, 1, 0, 0));
        apply_stimulus(mk(1, 2, 1, 1, 1, 3, 1, 0, 0, 0));
        apply_stimulus(mk(1, 2, 1, 1, 1, 3, 1, 0, 0, 0));
        apply_stimulus(reset_stim());
        apply_stimulus(idle());

        // HALT, drain, sticky Halted, then reset
        apply_stimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        repeat (5) apply_stimulus(idle());
        apply_stimulus(reset_stim());
        apply_stimulus(idle());

        // Random traffic; decode holds its instruction while stalled.
        prev = idle();
        halted_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            cur = rand_stim();
            if (last_stall && !cur.rst) begin
                prev.redirect = cur.redirect;
                cur = prev;
            end
            halted_cycles = m_halted ? halted_cycles + 1 : 0;
            if (halted_cycles > 4) cur.rst = 1'b1;
            apply_stimulus(cur);
            prev = cur;
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
